nios2_debug_scan_master: RTL

- Host-side driver for the Nios II debug slave's virtual-JTAG scan interface. It is the initiator of the UIR/CDR/SDR/E1DR scan sequence that the debug slave's TCK logic responds to.
- Accepts one command (2-bit IR plus SR_WIDTH-bit data word) and plays the complete scan sequence on a generated tck. Data is shifted in on tdi while the slave's tdo is captured.
- Returns the captured word through a valid/ready response port.
- Used in simulation and in the on-chip debug bring-up harness, where no physical JTAG hub exists.

---
 rtl/nios2_debug_scan_master.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/nios2_debug_scan_master.sv
// Host-side scan master for the Nios II debug slave's virtual-JTAG port.
// Plays UIR/CDR/SDR/E1DR/RTI on a divided tck and returns the captured DR word.
module nios2_debug_scan_master #(
  parameter int unsigned SR_WIDTH = 38,
  parameter int unsigned IR_WIDTH = 2,
  parameter int unsigned TCK_DIV  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [SR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [SR_WIDTH-1:0] rsp_data,
  output logic                tck,
  output logic                tdi,
  input  logic                tdo,
  output logic [IR_WIDTH-1:0] ir_in,
  output logic                vs_uir,
  output logic                vs_cdr,
  output logic                vs_sdr,
  output logic                vs_e1dr,
  output logic                jtag_state_rti
);

  localparam int unsigned HALF  = TCK_DIV / 2;
  localparam int unsigned PH_W  = $clog2(TCK_DIV);
  localparam int unsigned BIT_W = $clog2(SR_WIDTH);

  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(TCK_DIV - 1);
  localparam logic [PH_W-1:0]  PH_RISE  = PH_W'(HALF);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SR_WIDTH - 1);

  if (TCK_DIV < 2 || (TCK_DIV % 2) != 0 || SR_WIDTH < 2 || SR_WIDTH > 64 || IR_WIDTH < 1)
  begin : g_bad_params
    $error("nios2_debug_scan_master: illegal TCK_DIV/SR_WIDTH/IR_WIDTH");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_UIR,
    S_CDR,
    S_SDR,
    S_E1DR,
    S_RTI,
    S_RESP
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [PH_W-1:0]     phase;
  logic [BIT_W-1:0]    bit_cnt;
  logic [SR_WIDTH-1:0] sr;
  logic                accept_c;
  logic                period_end_c;
  logic                scan_active_c;

  // Next-state decode; every scan state lasts whole tck periods.
  always_comb begin
    state_next    = state;
    accept_c      = 1'b0;
    period_end_c  = (phase == PH_LAST);
    scan_active_c = (state != S_IDLE) && (state != S_RESP);
    case (state)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          accept_c   = 1'b1;
          state_next = S_UIR;
        end
      end
      S_UIR:  if (period_end_c) state_next = S_CDR;
      S_CDR:  if (period_end_c) state_next = S_SDR;
      S_SDR:  if (period_end_c && (bit_cnt == BIT_LAST)) state_next = S_E1DR;
      S_E1DR: if (period_end_c) state_next = S_RTI;
      S_RTI:  if (period_end_c) state_next = S_RESP;
      S_RESP: if (rsp_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      phase          <= '0;
      bit_cnt        <= '0;
      sr             <= '0;
      cmd_ready      <= 1'b1;
      rsp_valid      <= 1'b0;
      rsp_data       <= '0;
      tck            <= 1'b0;
      tdi            <= 1'b0;
      ir_in          <= '0;
      vs_uir         <= 1'b0;
      vs_cdr         <= 1'b0;
      vs_sdr         <= 1'b0;
      vs_e1dr        <= 1'b0;
      jtag_state_rti <= 1'b1;
    end else begin
      state <= state_next;

      if (scan_active_c) phase <= period_end_c ? '0 : phase + PH_W'(1);
      else               phase <= '0;

      if (state != S_SDR)   bit_cnt <= '0;
      else if (period_end_c) bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_W'(1);

      // tdo is captured on the same clk edge that raises tck.
      if (accept_c) begin
        sr    <= cmd_data;
        ir_in <= cmd_ir;
      end else if ((state == S_SDR) && (phase == PH_RISE)) begin
        sr <= {tdo, sr[SR_WIDTH-1:1]};
      end

      tck <= scan_active_c && (state_next != S_RESP) && (phase >= PH_RISE);

      if (state_next != S_SDR)                  tdi <= 1'b0;
      else if ((state == S_SDR) && (phase == '0)) tdi <= sr[0];

      if ((state == S_RTI) && period_end_c) begin
        rsp_valid <= 1'b1;
        rsp_data  <= sr;
      end else if ((state == S_RESP) && rsp_ready) begin
        rsp_valid <= 1'b0;
      end

      cmd_ready      <= (state_next == S_IDLE);
      vs_uir         <= (state_next == S_UIR);
      vs_cdr         <= (state_next == S_CDR);
      vs_sdr         <= (state_next == S_SDR);
      vs_e1dr        <= (state_next == S_E1DR);
      jtag_state_rti <= (state_next == S_IDLE) || (state_next == S_RTI) ||
                        (state_next == S_RESP);
    end
  end

endmodule
